// File: rtl/trace_arbiter.sv
// trace_arbiter: capture controller and round-robin arbiter in front of the
// trace buffer write port. Each source owns a one-entry holding register; one
// held word per cycle is granted and written out through a registered port.
//
// Handshake: wr_all[i] is a fire-and-forget strobe with no backpressure. The
// word is taken when the holding register is empty or is being granted that
// cycle, otherwise it is lost and counted in drop_cnt. On the buffer side
// wr_en is a one-cycle write strobe qualified by dout/src_id, and tb_rd is a
// one-cycle read strobe that frees a slot.
module trace_arbiter #(
    parameter int Fpay     = 32,
    parameter int SRC_NUM  = 5,
    parameter int TB_Depth = 512,
    localparam int SIw     = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1,
    localparam int Cw      = $clog2(TB_Depth) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SRC_NUM*Fpay-1:0] din_all,
    input  logic [SRC_NUM-1:0]      wr_all,
    input  logic [SRC_NUM-1:0]      ip_select,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    tb_rd,
    output logic                    wr_en,
    output logic [Fpay-1:0]         dout,
    output logic [SIw-1:0]          src_id,
    output logic [1:0]              state,
    output logic [Cw-1:0]           tb_count,
    output logic                    full,
    output logic [15:0]             drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                capture_en, arb_en, arm_start;

    logic [SRC_NUM-1:0]  valid_q;
    logic [Fpay-1:0]     hold_q [SRC_NUM];
    logic [SIw-1:0]      last_grant_q;

    logic                grant;
    logic [SIw-1:0]      winner;
    logic [SRC_NUM-1:0]  granted_vec;
    logic [Fpay-1:0]     grant_data;
    logic                room;
    logic [Cw:0]         occ_after;

    logic [SRC_NUM-1:0]  load_req, load_ok, drop_vec;
    logic [16:0]         drop_sum;
    logic [15:0]         drop_next;
    logic                rd_ok;

    assign state = state_q;
    assign full  = (tb_count == Cw'(TB_Depth));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: arm only acts from IDLE, stop only from CAPTURE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm)  state_d = CAPTURE;
            CAPTURE: if (stop) state_d = DRAIN;
            DRAIN:   if (valid_q == '0 && !grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State decode: loads only in CAPTURE, grants in CAPTURE and DRAIN
    always_comb begin
        capture_en = 1'b0;
        arb_en     = 1'b0;
        arm_start  = 1'b0;
        case (state_q)
            IDLE:    arm_start = arm;
            CAPTURE: begin
                capture_en = 1'b1;
                arb_en     = 1'b1;
            end
            DRAIN:   arb_en = 1'b1;
            default: ;
        endcase
    end

    // Round-robin pick: first valid source after the last winner, gated by
    // free space counting the write already in flight
    always_comb begin
        int idx;
        idx        = 0;
        grant      = 1'b0;
        winner     = '0;
        occ_after  = {1'b0, tb_count} + {{Cw{1'b0}}, wr_en};
        room       = (occ_after < (Cw+1)'(TB_Depth));
        for (int k = 1; k <= SRC_NUM; k++) begin
            idx = (int'(last_grant_q) + k) % SRC_NUM;
            if (!grant && valid_q[idx]) begin
                grant  = 1'b1;
                winner = SIw'(idx);
            end
        end
        if (!arb_en || !room) grant = 1'b0;
        granted_vec = '0;
        grant_data  = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (winner == SIw'(i)) begin
                granted_vec[i] = grant;
                grant_data     = hold_q[i];
            end
        end
    end

    // Load acceptance and drop accounting; a granted slot may be refilled
    always_comb begin
        load_req = wr_all & ip_select & {SRC_NUM{capture_en}};
        load_ok  = load_req & (~valid_q | granted_vec);
        drop_vec = load_req & ~load_ok;
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < SRC_NUM; i++) begin
            drop_sum = drop_sum + 17'(drop_vec[i]);
        end
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        rd_ok     = tb_rd && (tb_count != '0);
    end

    // Holding registers: new word wins over a same-cycle grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < SRC_NUM; i++) hold_q[i] <= '0;
        end else if (arm_start) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (load_ok[i]) begin
                    valid_q[i] <= 1'b1;
                    hold_q[i]  <= din_all[i*Fpay +: Fpay];
                end else if (granted_vec[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Registered write port and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en        <= 1'b0;
            dout         <= '0;
            src_id       <= '0;
            last_grant_q <= SIw'(SRC_NUM - 1);
        end else begin
            wr_en <= grant;
            if (grant) begin
                dout         <= grant_data;
                src_id       <= winner;
                last_grant_q <= winner;
            end
        end
    end

    // Buffer occupancy mirror; reads of an empty buffer are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tb_count <= '0;
        else       tb_count <= tb_count + Cw'(wr_en) - Cw'(rd_ok);
    end

    // Lost-word counter, cleared when a new capture is armed
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          drop_cnt <= '0;
        else if (arm_start) drop_cnt <= '0;
        else                drop_cnt <= drop_next;
    end

endmodule

// File: tb/tb_trace_arbiter.sv
// tb_trace_arbiter: bench for trace_arbiter with a shallow buffer so the
// full/back-pressure corner is reachable quickly.
module tb_trace_arbiter;

    localparam int FPAY  = 32;
    localparam int NSRC  = 5;
    localparam int DEPTH = 8;
    localparam int SIW   = 3;
    localparam int CW    = 4;
    localparam int W     = SIW + FPAY;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NSRC*FPAY-1:0] din_all = '0;
    logic [NSRC-1:0]      wr_all = '0;
    logic [NSRC-1:0]      ip_select = '0;
    logic                 arm = 1'b0;
    logic                 stop = 1'b0;
    logic                 tb_rd = 1'b0;
    logic                 wr_en;
    logic [FPAY-1:0]      dout;
    logic [SIW-1:0]       src_id;
    logic [1:0]           state;
    logic [CW-1:0]        tb_count;
    logic                 full;
    logic [15:0]          drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [4:0]  wr;
        logic [4:0]  sel;
        int          n;
        logic [14:0] ord;
    } vec_t;
    vec_t vecs[9];

    trace_arbiter #(.Fpay(FPAY), .SRC_NUM(NSRC), .TB_Depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .din_all(din_all), .wr_all(wr_all),
        .ip_select(ip_select), .arm(arm), .stop(stop), .tb_rd(tb_rd),
        .wr_en(wr_en), .dout(dout), .src_id(src_id), .state(state),
        .tb_count(tb_count), .full(full), .drop_cnt(drop_cnt)
    );

    // clock / reset-independent timebase
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard: every observed write must match the head of exp_q
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", src_id, dout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("write", 64'({src_id, dout}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int i, input logic [FPAY-1:0] v);
        din_all[i*FPAY +: FPAY] = v;
    endtask

    task automatic push(input int s, input logic [FPAY-1:0] d);
        exp_q.push_back({SIW'(s), d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_all = '0; arm = 1'b0; stop = 1'b0; tb_rd = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    function automatic logic [FPAY-1:0] vdata(input int v, input int i);
        return {8'hC0, 8'(v), 8'h00, 8'(i)};
    endfunction

    function automatic logic [FPAY-1:0] sdata(input int i, input int c);
        return {8'hB0, 8'(i), 16'(c)};
    endfunction

    initial begin
        int wr_seen, d10, d15, s;
        logic [2:0] id;

        vecs[0] = '{5'b11111, 5'b11111, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[1] = '{5'b11111, 5'b11111, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[2] = '{5'b10100, 5'b11111, 2, {9'd0, 3'd4, 3'd2}};
        vecs[3] = '{5'b00011, 5'b11111, 2, {9'd0, 3'd1, 3'd0}};
        vecs[4] = '{5'b11111, 5'b01010, 2, {9'd0, 3'd1, 3'd3}};
        vecs[5] = '{5'b10001, 5'b10001, 2, {9'd0, 3'd0, 3'd4}};
        vecs[6] = '{5'b00110, 5'b00000, 0, 15'd0};
        vecs[7] = '{5'b01100, 5'b11111, 2, {9'd0, 3'd3, 3'd2}};
        vecs[8] = '{5'b01001, 5'b11111, 2, {9'd0, 3'd3, 3'd0}};

        // 1: reset with random inputs
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            din_all   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            wr_all    = NSRC'($urandom);
            ip_select = NSRC'($urandom);
            arm       = 1'($urandom_range(0, 1));
            stop      = 1'($urandom_range(0, 1));
            tb_rd     = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_src_id", 64'(src_id), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_tb_count", 64'(tb_count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        wr_all = '0; arm = 1'b0; stop = 1'b0; tb_rd = 1'b0; ip_select = '0;
        reset = 1'b0;
        tick();
        check("post_rst_state", 64'(state), 64'd0);

        // 2: single-word latency
        ip_select = 5'b00001;
        do_arm();
        check("arm_state", 64'(state), 64'd1);
        set_din(0, 32'hA5A5_0001);
        wr_all = 5'b00001;
        push(0, 32'hA5A5_0001);
        tick();
        wr_all = '0;
        check("lat_t1_wr_en", 64'(wr_en), 64'd0);
        tick();
        check("lat_t2_wr_en", 64'(wr_en), 64'd1);
        tick();
        check("lat_t3_tb_count", 64'(tb_count), 64'd1);
        wait_drain("lat_drain", 10);

        // 3: table-driven single-cycle strobe patterns, round-robin order
        do_reset();
        tb_rd = 1'b1;
        do_arm();
        for (int v = 0; v < 9; v++) begin
            ip_select = vecs[v].sel;
            for (int i = 0; i < NSRC; i++) set_din(i, vdata(v, i));
            wr_all = vecs[v].wr;
            for (int k = 0; k < vecs[v].n; k++) begin
                id = vecs[v].ord[3*k +: 3];
                push(int'(id), vdata(v, int'(id)));
            end
            tick();
            wr_all = '0;
            wait_drain($sformatf("vec%0d_drain", v), 30);
            check($sformatf("vec%0d_drop", v), 64'(drop_cnt), 64'd0);
        end

        // 4: two sources strobing every cycle
        do_reset();
        tb_rd = 1'b1;
        ip_select = 5'b11111;
        do_arm();
        push(0, sdata(0, 0));
        push(1, sdata(1, 0));
        for (int c = 3; c <= 21; c++) begin
            s = (c + 1) % 2;
            push(s, sdata(s, c - 2));
        end
        wr_seen = 0; d10 = 0; d15 = 0;
        for (int c = 0; c < 20; c++) begin
            set_din(0, sdata(0, c));
            set_din(1, sdata(1, c));
            wr_all = 5'b00011;
            tick();
            if (c >= 1 && wr_en) wr_seen++;
            if (c == 10) d10 = int'(drop_cnt);
            if (c == 15) d15 = int'(drop_cnt);
        end
        wr_all = '0;
        check("stream_wr_continuous", 64'(wr_seen), 64'd19);
        check("stream_drop_rate", 64'(d15 - d10), 64'd5);
        check("stream_drop_total", 64'(drop_cnt), 64'd19);
        wait_drain("stream_drain", 20);

        // arm/stop rules
        do_arm();
        check("arm_in_capture_state", 64'(state), 64'd1);
        check("arm_in_capture_drop", 64'(drop_cnt), 64'd19);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_state", 64'(state), 64'd2);
        tick();
        check("empty_drain_idle", 64'(state), 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_in_idle", 64'(state), 64'd0);
        arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
        check("arm_over_stop", 64'(state), 64'd1);
        check("arm_clears_drop", 64'(drop_cnt), 64'd0);

        // 5: fill to full, one held and one dropped, then a single read
        do_reset();
        ip_select = 5'b00001;
        do_arm();
        for (int c = 0; c < 10; c++) begin
            set_din(0, {8'hF5, 24'(c)});
            wr_all = 5'b00001;
            if (c < 8) push(0, {8'hF5, 24'(c)});
            tick();
        end
        wr_all = '0;
        wait_drain("fill_drain", 20);
        tick(); tick();
        check("fill_tb_count", 64'(tb_count), 64'd8);
        check("fill_full", 64'(full), 64'd1);
        check("fill_drop", 64'(drop_cnt), 64'd1);
        push(0, {8'hF5, 24'd8});
        tb_rd = 1'b1;
        tick();
        tb_rd = 1'b0;
        check("rd_tb_count", 64'(tb_count), 64'd7);
        check("rd_full", 64'(full), 64'd0);
        tick();
        check("rd_refill_wr_en", 64'(wr_en), 64'd1);
        tick();
        check("refull_tb_count", 64'(tb_count), 64'd8);
        check("refull_full", 64'(full), 64'd1);
        wait_drain("refill_drain", 10);

        // 6: stop with three held words, drain to IDLE
        do_reset();
        ip_select = 5'b11111;
        do_arm();
        for (int c = 0; c < 8; c++) begin
            set_din(0, {8'hE0, 24'(c)});
            wr_all = 5'b00001;
            push(0, {8'hE0, 24'(c)});
            tick();
        end
        wr_all = '0;
        wait_drain("d6_fill", 20);
        check("d6_full", 64'(full), 64'd1);
        for (int i = 1; i < 4; i++) set_din(i, {8'hD6, 24'(i)});
        wr_all = 5'b01110;
        tick();
        wr_all = '0;
        tick();
        check("d6_held_no_write", 64'(wr_en), 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("d6_drain_state", 64'(state), 64'd2);
        tick(); tick();
        check("d6_drain_waits", 64'(state), 64'd2);
        for (int i = 1; i < 4; i++) push(i, {8'hD6, 24'(i)});
        tb_rd = 1'b1;
        wait_drain("d6_drain", 20);
        check("d6_idle", 64'(state), 64'd0);
        wr_all = 5'b11111;
        tick(); tick(); tick();
        wr_all = '0;
        tick(); tick(); tick();
        check("d6_idle_no_drop", 64'(drop_cnt), 64'd0);
        check("d6_idle_state", 64'(state), 64'd0);

        // reset in the middle of a drain
        do_reset();
        ip_select = 5'b11111;
        do_arm();
        for (int c = 0; c < 8; c++) begin
            set_din(0, {8'hE1, 24'(c)});
            wr_all = 5'b00001;
            push(0, {8'hE1, 24'(c)});
            tick();
        end
        wr_all = '0;
        wait_drain("r6_fill", 20);
        wr_all = 5'b01110;
        tick();
        wr_all = '0;
        stop = 1'b1; tick(); stop = 1'b0;
        check("r6_drain_state", 64'(state), 64'd2);
        reset = 1'b1;
        tb_rd = 1'b1;
        #1;
        check("r6_async_wr_en", 64'(wr_en), 64'd0);
        check("r6_async_state", 64'(state), 64'd0);
        check("r6_async_tb_count", 64'(tb_count), 64'd0);
        check("r6_async_full", 64'(full), 64'd0);
        check("r6_async_dout", 64'(dout), 64'd0);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("r6_after_state", 64'(state), 64'd0);
        check("r6_after_count", 64'(tb_count), 64'd0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
